// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU op codes, opcode/funct values and
// the packed decode-control bundle carried between pipeline stages.
package mips_pkg;

   typedef enum logic [3:0] {
      ALUOP_AND     = 4'b0000,
      ALUOP_OR      = 4'b0001,
      ALUOP_ADD     = 4'b0010,
      ALUOP_XOR     = 4'b0011,
      ALUOP_SLL     = 4'b0100,
      ALUOP_SRL     = 4'b0101,
      ALUOP_SUB     = 4'b0110,
      ALUOP_SLT     = 4'b0111,
      ALUOP_SRA     = 4'b1000,
      ALUOP_BEQ     = 4'b1001,
      ALUOP_BNE     = 4'b1010,
      ALUOP_ILLEGAL = 4'b1011,
      ALUOP_NOR     = 4'b1100
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // Seven decoder control bits plus the slot-valid bit, then the ALU op.
   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memwrite;
      logic       branch;
      logic       alusrc;
      logic       alusrc_shamt;
      logic       regdst;
      logic       valid;
      logic [3:0] alucontrol;
   } ctrl_t;

endpackage

// File: rtl/hazard_lw_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by
// the instruction in ID forces a one-cycle stall.
module hazard_lw_detect #(
   parameter int REG_AW = 5
) (
   input  logic              valid_e,
   input  logic              memtoreg_e,
   input  logic [REG_AW-1:0] rt_e,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   output logic              lwstall
);

   // Raw field compare; a false stall on an unused field is harmless.
   always_comb begin
      lwstall = valid_e & memtoreg_e & (rt_e != '0) & valid_d &
                ((rt_e == rs_d) | (rt_e == rt_d));
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squashing and a
// sticky illegal-instruction flag.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter int         REG_AW      = 5,
   parameter logic [3:0] ALU_ILLEGAL = 4'b1011
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWriteD,
   input  logic              MemtoRegD,
   input  logic              MemWriteD,
   input  logic              BranchD,
   input  logic              ALUSrcD,
   input  logic              ALUSrc_shamtD,
   input  logic              RegDstD,
   input  logic [3:0]        ALUControlD,
   input  logic              ValidD,
   input  logic [DATA_W-1:0] RD1D,
   input  logic [DATA_W-1:0] RD2D,
   input  logic [REG_AW-1:0] RsD,
   input  logic [REG_AW-1:0] RtD,
   input  logic [REG_AW-1:0] RdD,
   input  logic [REG_AW-1:0] ShamtD,
   input  logic [DATA_W-1:0] SignImmD,
   input  logic [DATA_W-1:0] PCPlus4D,
   input  logic              FlushE,
   output logic              RegWriteE,
   output logic              MemtoRegE,
   output logic              MemWriteE,
   output logic              BranchE,
   output logic              ALUSrcE,
   output logic              ALUSrc_shamtE,
   output logic              RegDstE,
   output logic [3:0]        ALUControlE,
   output logic              ValidE,
   output logic [DATA_W-1:0] RD1E,
   output logic [DATA_W-1:0] RD2E,
   output logic [DATA_W-1:0] SignImmE,
   output logic [DATA_W-1:0] PCPlus4E,
   output logic [REG_AW-1:0] RsE,
   output logic [REG_AW-1:0] RtE,
   output logic [REG_AW-1:0] RdE,
   output logic [REG_AW-1:0] ShamtE,
   output logic              StallF,
   output logic              StallD,
   output logic              IllegalSeen
);

   ctrl_t ctrl_d;
   ctrl_t ctrl_e;
   logic  lwstall;
   logic  bubble;
   logic  illegal_load;

   hazard_lw_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_lw_detect (
      .valid_e    (ctrl_e.valid),
      .memtoreg_e (ctrl_e.memtoreg),
      .rt_e       (RtE),
      .valid_d    (ValidD),
      .rs_d       (RsD),
      .rt_d       (RtD),
      .lwstall    (lwstall)
   );

   // Gather decoder controls and decide whether this edge loads a bubble.
   always_comb begin
      ctrl_d = '{
         regwrite:     RegWriteD,
         memtoreg:     MemtoRegD,
         memwrite:     MemWriteD,
         branch:       BranchD,
         alusrc:       ALUSrcD,
         alusrc_shamt: ALUSrc_shamtD,
         regdst:       RegDstD,
         valid:        ValidD,
         alucontrol:   ALUControlD
      };
      // An empty slot is squashed exactly like a flush or stall bubble.
      bubble       = FlushE | lwstall | ~ValidD;
      illegal_load = ~bubble & (ALUControlD == ALU_ILLEGAL);
   end

   // Stage register: data always follows D, control is zeroed on a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_e      <= '0;
         RD1E        <= '0;
         RD2E        <= '0;
         SignImmE    <= '0;
         PCPlus4E    <= '0;
         RsE         <= '0;
         RtE         <= '0;
         RdE         <= '0;
         ShamtE      <= '0;
         IllegalSeen <= 1'b0;
      end else begin
         ctrl_e   <= bubble ? '0 : ctrl_d;
         RD1E     <= RD1D;
         RD2E     <= RD2D;
         SignImmE <= SignImmD;
         PCPlus4E <= PCPlus4D;
         RsE      <= RsD;
         RtE      <= RtD;
         RdE      <= RdD;
         ShamtE   <= ShamtD;
         if (illegal_load) begin
            IllegalSeen <= 1'b1;
         end
      end
   end

   // Unpack registered controls and publish the hold requests.
   always_comb begin
      RegWriteE     = ctrl_e.regwrite;
      MemtoRegE     = ctrl_e.memtoreg;
      MemWriteE     = ctrl_e.memwrite;
      BranchE       = ctrl_e.branch;
      ALUSrcE       = ctrl_e.alusrc;
      ALUSrc_shamtE = ctrl_e.alusrc_shamt;
      RegDstE       = ctrl_e.regdst;
      ValidE        = ctrl_e.valid;
      ALUControlE   = ctrl_e.alucontrol;
      StallF        = lwstall;
      StallD        = lwstall;
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus pushes expected stall and
// EX-stage contents; independent monitors pop and compare.
module tb_id_ex_stage;

   typedef struct packed {
      logic        rw, m2r, mw, br, asrc, ashamt, rdst;
      logic [3:0]  aluc;
      logic        v;
      logic [31:0] rd1, rd2, imm, pc4;
      logic [4:0]  rs, rt, rd, sh;
   } stage_t;

   typedef struct packed {
      stage_t e;
      logic   ill;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSrc_shamtD, RegDstD;
   logic [3:0] ALUControlD;
   logic ValidD;
   logic [31:0] RD1D, RD2D, SignImmD, PCPlus4D;
   logic [4:0] RsD, RtD, RdD, ShamtD;
   logic FlushE;
   logic RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, ALUSrc_shamtE, RegDstE;
   logic [3:0] ALUControlE;
   logic ValidE;
   logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E;
   logic [4:0] RsE, RtE, RdE, ShamtE;
   logic StallF, StallD, IllegalSeen;

   int compared   = 0;
   int mismatched = 0;

   logic sq[$];
   exp_t eq[$];

   // Reference view of what EX holds, plus the sticky flag.
   stage_t m_e  = '0;
   logic   m_ill = 1'b0;
   logic   last_stall = 1'b0;
   logic   last_flush = 1'b0;
   stage_t last_d = '0;

   always #5 clk = ~clk;

   id_ex_stage #(
      .DATA_W      (32),
      .REG_AW      (5),
      .ALU_ILLEGAL (4'b1011)
   ) dut (
      .clk(clk), .reset(reset),
      .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
      .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUSrc_shamtD(ALUSrc_shamtD),
      .RegDstD(RegDstD), .ALUControlD(ALUControlD), .ValidD(ValidD),
      .RD1D(RD1D), .RD2D(RD2D), .RsD(RsD), .RtD(RtD), .RdD(RdD), .ShamtD(ShamtD),
      .SignImmD(SignImmD), .PCPlus4D(PCPlus4D), .FlushE(FlushE),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUSrc_shamtE(ALUSrc_shamtE),
      .RegDstE(RegDstE), .ALUControlE(ALUControlE), .ValidE(ValidE),
      .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
      .RsE(RsE), .RtE(RtE), .RdE(RdE), .ShamtE(ShamtE),
      .StallF(StallF), .StallD(StallD), .IllegalSeen(IllegalSeen)
   );

   // A load in EX blocks any ID instruction naming its destination (not $0).
   function automatic logic uses_load(stage_t ex, stage_t id);
      return ex.v && ex.m2r && (ex.rt != 5'd0) && id.v &&
             ((ex.rt == id.rs) || (ex.rt == id.rt));
   endfunction

   function automatic stage_t mk(logic rw, logic m2r, logic mw, logic asrc, logic rdst,
                                 logic [3:0] aluc, logic [4:0] rs, logic [4:0] rt,
                                 logic [4:0] rd);
      stage_t d;
      d = '0;
      d.rw = rw; d.m2r = m2r; d.mw = mw; d.asrc = asrc; d.rdst = rdst;
      d.aluc = aluc; d.v = 1'b1;
      d.rs = rs; d.rt = rt; d.rd = rd;
      d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom; d.pc4 = $urandom;
      d.sh = 5'($urandom_range(0, 31));
      return d;
   endfunction

   function automatic stage_t rand_instr();
      stage_t d;
      d.v      = ($urandom_range(0, 9) != 0);
      d.rw     = 1'($urandom);
      d.m2r    = ($urandom_range(0, 2) == 0);
      d.mw     = 1'($urandom);
      d.br     = 1'($urandom);
      d.asrc   = 1'($urandom);
      d.ashamt = 1'($urandom);
      d.rdst   = 1'($urandom);
      d.aluc   = ($urandom_range(0, 7) == 0) ? 4'b1011 : 4'($urandom_range(0, 12));
      d.rd1 = $urandom; d.rd2 = $urandom; d.imm = $urandom; d.pc4 = $urandom;
      d.rs = 5'($urandom_range(0, 6));
      d.rt = 5'($urandom_range(0, 6));
      d.rd = 5'($urandom_range(0, 31));
      d.sh = 5'($urandom_range(0, 31));
      return d;
   endfunction

   // One cycle of stimulus: drive, predict, enqueue expectations.
   task automatic issue(input stage_t d, input logic fl, input logic rst);
      logic st;
      @(posedge clk);
      #2;
      reset = rst; FlushE = fl;
      RegWriteD = d.rw; MemtoRegD = d.m2r; MemWriteD = d.mw; BranchD = d.br;
      ALUSrcD = d.asrc; ALUSrc_shamtD = d.ashamt; RegDstD = d.rdst;
      ALUControlD = d.aluc; ValidD = d.v;
      RD1D = d.rd1; RD2D = d.rd2; SignImmD = d.imm; PCPlus4D = d.pc4;
      RsD = d.rs; RtD = d.rt; RdD = d.rd; ShamtD = d.sh;
      st = uses_load(m_e, d);
      sq.push_back(st);
      if (rst) begin
         m_e   = '0;
         m_ill = 1'b0;
      end else begin
         m_e = d;
         if (fl || st || !d.v) begin
            {m_e.rw, m_e.m2r, m_e.mw, m_e.br, m_e.asrc, m_e.ashamt, m_e.rdst} = '0;
            m_e.aluc = 4'd0;
            m_e.v    = 1'b0;
         end else if (d.aluc == 4'b1011) begin
            m_ill = 1'b1;
         end
      end
      eq.push_back('{e: m_e, ill: m_ill});
      last_stall = st;
      last_flush = fl;
      last_d     = d;
   endtask

   // Stall monitor: combinational outputs, sampled mid-cycle.
   initial begin
      logic s;
      forever begin
         @(negedge clk);
         if (sq.size() > 0) begin
            s = sq.pop_front();
            compared++;
            if (StallF !== s) begin
               mismatched++;
               $display("FAIL stallF at %0t: got %b want %b", $time, StallF, s);
            end
            compared++;
            if (StallD !== s) begin
               mismatched++;
               $display("FAIL stallD at %0t: got %b want %b", $time, StallD, s);
            end
         end
      end
   end

   // EX monitor: registered outputs, sampled just after the edge.
   initial begin
      exp_t   x;
      stage_t a;
      forever begin
         @(posedge clk);
         #1;
         if (eq.size() > 0) begin
            x = eq.pop_front();
            a = '{rw: RegWriteE, m2r: MemtoRegE, mw: MemWriteE, br: BranchE,
                  asrc: ALUSrcE, ashamt: ALUSrc_shamtE, rdst: RegDstE,
                  aluc: ALUControlE, v: ValidE, rd1: RD1E, rd2: RD2E,
                  imm: SignImmE, pc4: PCPlus4E, rs: RsE, rt: RtE, rd: RdE, sh: ShamtE};
            compared++;
            if (a !== x.e) begin
               mismatched++;
               $display("FAIL ex_regs at %0t: got %h want %h", $time, a, x.e);
            end
            compared++;
            if (IllegalSeen !== x.ill) begin
               mismatched++;
               $display("FAIL illegal_seen at %0t: got %b want %b", $time, IllegalSeen, x.ill);
            end
         end
      end
   end

   initial begin
      stage_t add_i, lw_i, d;
      reset = 1'b1; FlushE = 1'b0;
      {RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSrc_shamtD, RegDstD} = '0;
      ALUControlD = 4'd0; ValidD = 1'b0;
      RD1D = '0; RD2D = '0; SignImmD = '0; PCPlus4D = '0;
      RsD = '0; RtD = '0; RdD = '0; ShamtD = '0;

      issue('0, 1'b0, 1'b1);

      // pass-through add, then reset mid-stream
      add_i = mk(1, 0, 0, 0, 1, 4'b0010, 5'd1, 5'd2, 5'd3);
      add_i.rd1 = 32'd5; add_i.rd2 = 32'd7;
      issue(add_i, 1'b0, 1'b0);
      issue(add_i, 1'b0, 1'b1);
      issue(add_i, 1'b0, 1'b0);

      // load-use: lw $8, then add using $8 held for one stall cycle
      lw_i  = mk(1, 1, 0, 1, 0, 4'b0010, 5'd4, 5'd8, 5'd0);
      add_i = mk(1, 0, 0, 0, 1, 4'b0010, 5'd8, 5'd2, 5'd3);
      issue(lw_i, 1'b0, 1'b0);
      issue(add_i, 1'b0, 1'b0);
      issue(add_i, 1'b0, 1'b0);

      // back-to-back loads, each stalling its consumer
      issue(lw_i, 1'b0, 1'b0);
      issue(mk(1, 1, 0, 1, 0, 4'b0010, 5'd8, 5'd9, 5'd0), 1'b0, 1'b0);
      issue(mk(1, 1, 0, 1, 0, 4'b0010, 5'd8, 5'd9, 5'd0), 1'b0, 1'b0);
      issue(mk(1, 0, 0, 0, 1, 4'b0010, 5'd1, 5'd9, 5'd3), 1'b0, 1'b0);
      issue(mk(1, 0, 0, 0, 1, 4'b0010, 5'd1, 5'd9, 5'd3), 1'b0, 1'b0);

      // $0 destination and non-matching register never stall
      issue(mk(1, 1, 0, 1, 0, 4'b0010, 5'd4, 5'd0, 5'd0), 1'b0, 1'b0);
      issue(mk(1, 0, 0, 0, 1, 4'b0010, 5'd0, 5'd0, 5'd3), 1'b0, 1'b0);
      issue(lw_i, 1'b0, 1'b0);
      issue(mk(1, 0, 0, 0, 1, 4'b0010, 5'd9, 5'd9, 5'd3), 1'b0, 1'b0);

      // flush of a store, then flush coincident with a load-use stall
      issue(mk(0, 0, 1, 1, 0, 4'b0010, 5'd1, 5'd2, 5'd0), 1'b1, 1'b0);
      issue(lw_i, 1'b0, 1'b0);
      issue(add_i, 1'b1, 1'b0);
      issue(add_i, 1'b0, 1'b0);

      // illegal op sets the sticky flag and it survives normal traffic
      issue(mk(0, 0, 0, 0, 0, 4'b1011, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
      for (int unsigned i = 0; i < 10; i++) begin
         issue(mk(1, 0, 0, 0, 1, 4'b0110, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);
      end
      // flushed illegal op leaves the flag clear
      issue('0, 1'b0, 1'b1);
      issue(mk(0, 0, 0, 0, 0, 4'b1011, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0);
      issue(mk(1, 0, 0, 0, 1, 4'b0010, 5'd1, 5'd2, 5'd3), 1'b0, 1'b0);

      // randomized traffic; a stalled instruction is re-presented by IF/ID
      for (int unsigned i = 0; i < 400; i++) begin
         if (last_stall && !last_flush) d = last_d;
         else                           d = rand_instr();
         issue(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
      end

      repeat (3) @(posedge clk);
      #3;
      if (sq.size() != 0 || eq.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d/%0d pending want 0/0", sq.size(), eq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
